// File: rtl/v_pkg.sv
// Vector LSU shared types: request op encodings, transfer FSM states and the
// lmul-to-beat-count helper used by the data memory response block.
package v_pkg;

    typedef enum logic [3:0] {
        LSU_NONE  = 4'd0,
        LSU_LOAD  = 4'd1,
        LSU_STORE = 4'd2
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } vdmem_state_e;

    localparam int unsigned ADDR_BITS = 14;
    localparam int unsigned ROW_BITS  = 12;
    localparam int unsigned NUM_BANKS = 4;

    // Fractional lmul settings still move a single 4-word beat.
    function automatic logic [3:0] lmul_to_beats(input logic [2:0] lmul);
        logic [3:0] n;
        case (lmul)
            3'd0:    n = 4'd1;
            3'd1:    n = 4'd2;
            3'd2:    n = 4'd4;
            3'd3:    n = 4'd8;
            default: n = 4'd1;
        endcase
        return n;
    endfunction

    function automatic logic lmul_legal(input logic [2:0] lmul);
        return (lmul != 3'd4);
    endfunction

endpackage

// File: rtl/constants.vh
// Shared data-memory constants for the vector LSU data memory.
`ifndef CONSTANTS_VH
`define CONSTANTS_VH
`define DATAMEM_BITS 32
`endif

// File: rtl/v_dmem_bank.sv
// One data-memory bank: 4096 words, synchronous write and registered read.
// Contents are deliberately never reset.
`include "constants.vh"

module v_dmem_bank
    import v_pkg::*;
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [ROW_BITS-1:0]      addr,
    input  logic [`DATAMEM_BITS-1:0] wdata,
    output logic [`DATAMEM_BITS-1:0] rdata
);

    logic [`DATAMEM_BITS-1:0] mem_r [0:(1<<ROW_BITS)-1];

    // Storage array with one-cycle read latency.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/v_dmem_resp.sv
// Banked vector data memory answering unit-stride LSU loads/stores of 1..8
// four-word beats. Optional beat counters are enabled with VDMEM_PERF_EN.
`include "constants.vh"

module v_dmem_resp
    import v_pkg::*;
(
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     v_lsu_req,
    input  logic [3:0]               v_lsu_op,
    input  logic [13:0]              v_data_addr,
    input  logic [2:0]               lmul,
    input  logic [`DATAMEM_BITS-1:0] v_store_data_0,
    input  logic [`DATAMEM_BITS-1:0] v_store_data_1,
    input  logic [`DATAMEM_BITS-1:0] v_store_data_2,
    input  logic [`DATAMEM_BITS-1:0] v_store_data_3,
    output logic [`DATAMEM_BITS-1:0] v_load_data_0,
    output logic [`DATAMEM_BITS-1:0] v_load_data_1,
    output logic [`DATAMEM_BITS-1:0] v_load_data_2,
    output logic [`DATAMEM_BITS-1:0] v_load_data_3,
    output logic                     v_load_valid,
    output logic                     v_lsu_busy,
    output logic                     v_lsu_done,
    output logic                     err_op
`ifdef VDMEM_PERF_EN
    ,
    output logic [31:0]              perf_ld_beats,
    output logic [31:0]              perf_st_beats
`endif
);

    localparam int W = `DATAMEM_BITS;

    vdmem_state_e  state_r;
    vdmem_state_e  state_s;
    logic          accept_s;
    logic          err_s;
    logic          legal_s;
    logic          last_s;
    logic          we_s;
    logic [13:0]   base_r;
    logic [3:0]    beats_r;
    logic [2:0]    beat_r;
    logic          err_r;
    logic          valid_r;

    logic [W-1:0]  store_s [4];
    logic [W-1:0]  wdata_s [4];
    logic [W-1:0]  rdata_s [4];
    logic [W-1:0]  load_s  [4];
    logic [1:0]    word_s  [4];
    logic [13:0]   waddr_s [4];
    logic [11:0]   row_s   [4];

    assign store_s[0] = v_store_data_0;
    assign store_s[1] = v_store_data_1;
    assign store_s[2] = v_store_data_2;
    assign store_s[3] = v_store_data_3;

    assign legal_s = lmul_legal(lmul);
    assign last_s  = ({1'b0, beat_r} == (beats_r - 4'd1));

    // Next-state logic; requests are only looked at while idle.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (v_lsu_req && (v_lsu_op != LSU_NONE)) begin
                    if (legal_s && (v_lsu_op == LSU_LOAD)) begin
                        accept_s = 1'b1;
                        state_s  = ST_LOAD;
                    end else if (legal_s && (v_lsu_op == LSU_STORE)) begin
                        accept_s = 1'b1;
                        state_s  = ST_STORE;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD, ST_STORE: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transfer context, beat counter and one-cycle status flags.
    always_ff @(posedge clk) begin
        if (nrst) begin
            base_r  <= 14'd0;
            beats_r <= 4'd1;
            beat_r  <= 3'd0;
            err_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            err_r   <= err_s;
            valid_r <= (state_r == ST_LOAD);
            if (accept_s) begin
                base_r  <= v_data_addr;
                beats_r <= lmul_to_beats(lmul);
                beat_r  <= 3'd0;
            end else if ((state_r == ST_LOAD) || (state_r == ST_STORE)) begin
                beat_r <= beat_r + 3'd1;
            end else begin
                beat_r <= beat_r;
            end
        end
    end

    // Bank j always serves word (j - base[1:0]) of the beat, so rotating by
    // the base offset puts word k on port k for any alignment.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            word_s[j]  = 2'(j) - base_r[1:0];
            waddr_s[j] = base_r + {9'd0, beat_r, 2'b00} + {12'd0, word_s[j]};
            row_s[j]   = waddr_s[j][13:2];
            wdata_s[j] = store_s[word_s[j]];
            if (valid_r) begin
                load_s[j] = rdata_s[2'(j) + base_r[1:0]];
            end else begin
                load_s[j] = {W{1'b0}};
            end
        end
    end

    // A reset cycle must not commit the beat that was in flight.
    assign we_s = (state_r == ST_STORE) && !nrst;

    generate
        for (genvar j = 0; j < NUM_BANKS; j++) begin : g_bank
            v_dmem_bank u_bank (
                .clk   (clk),
                .we    (we_s),
                .addr  (row_s[j]),
                .wdata (wdata_s[j]),
                .rdata (rdata_s[j])
            );
        end
    endgenerate

    assign v_load_data_0 = load_s[0];
    assign v_load_data_1 = load_s[1];
    assign v_load_data_2 = load_s[2];
    assign v_load_data_3 = load_s[3];
    assign v_load_valid  = valid_r;
    assign v_lsu_busy    = (state_r != ST_IDLE);
    assign v_lsu_done    = (state_r == ST_DONE);
    assign err_op        = err_r;

`ifdef VDMEM_PERF_EN
    logic [31:0] perf_ld_r;
    logic [31:0] perf_st_r;

    // Beat counters: a load beat completes when its data is presented.
    always_ff @(posedge clk) begin
        if (nrst) begin
            perf_ld_r <= 32'd0;
            perf_st_r <= 32'd0;
        end else begin
            if (valid_r) begin
                perf_ld_r <= perf_ld_r + 32'd1;
            end else begin
                perf_ld_r <= perf_ld_r;
            end
            if (we_s) begin
                perf_st_r <= perf_st_r + 32'd1;
            end else begin
                perf_st_r <= perf_st_r;
            end
        end
    end

    assign perf_ld_beats = perf_ld_r;
    assign perf_st_beats = perf_st_r;
`endif

endmodule

// File: tb/tb_v_dmem_resp.sv
// Scoreboard bench for v_dmem_resp: directed transfers push expected beats,
// done and error pulses into queues that a negedge monitor drains.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 32
`endif

module tb_v_dmem_resp;

    localparam int W = `DATAMEM_BITS;

    typedef struct packed {
        int               cyc;
        logic [3:0][W-1:0] d;
    } ld_exp_t;

    logic          clk = 1'b0;
    logic          nrst;
    logic          v_lsu_req;
    logic [3:0]    v_lsu_op;
    logic [13:0]   v_data_addr;
    logic [2:0]    lmul;
    logic [W-1:0]  sd [4];
    logic [W-1:0]  v_load_data_0, v_load_data_1, v_load_data_2, v_load_data_3;
    logic          v_load_valid, v_lsu_busy, v_lsu_done, err_op;
`ifdef VDMEM_PERF_EN
    logic [31:0]   perf_ld_beats, perf_st_beats;
`endif

    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    ld_exp_t       ld_q[$];
    int            done_q[$];
    int            err_q[$];
    logic [W-1:0]  mdl [16384];
    logic [W-1:0]  sdata [32];

    v_dmem_resp dut (
        .clk            (clk),
        .nrst           (nrst),
        .v_lsu_req      (v_lsu_req),
        .v_lsu_op       (v_lsu_op),
        .v_data_addr    (v_data_addr),
        .lmul           (lmul),
        .v_store_data_0 (sd[0]),
        .v_store_data_1 (sd[1]),
        .v_store_data_2 (sd[2]),
        .v_store_data_3 (sd[3]),
        .v_load_data_0  (v_load_data_0),
        .v_load_data_1  (v_load_data_1),
        .v_load_data_2  (v_load_data_2),
        .v_load_data_3  (v_load_data_3),
        .v_load_valid   (v_load_valid),
        .v_lsu_busy     (v_lsu_busy),
        .v_lsu_done     (v_lsu_done),
        .err_op         (err_op)
`ifdef VDMEM_PERF_EN
        ,
        .perf_ld_beats  (perf_ld_beats),
        .perf_st_beats  (perf_st_beats)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented output event is matched against the queues.
    always @(negedge clk) begin
        ld_exp_t e;
        int      t;
        if (v_load_valid) begin
            if (ld_q.size() == 0) begin
                chk("unexpected_valid", 64'(v_load_valid), 64'd0);
            end else begin
                e = ld_q.pop_front();
                chk("valid_cycle", 64'(cyc), 64'(e.cyc));
                chk("load_w0", 64'(v_load_data_0), 64'(e.d[0]));
                chk("load_w1", 64'(v_load_data_1), 64'(e.d[1]));
                chk("load_w2", 64'(v_load_data_2), 64'(e.d[2]));
                chk("load_w3", 64'(v_load_data_3), 64'(e.d[3]));
            end
        end else begin
            chk("idle_data_zero",
                64'(v_load_data_0 | v_load_data_1 | v_load_data_2 | v_load_data_3), 64'd0);
        end
        if (v_lsu_done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 64'(v_lsu_done), 64'd0);
            end else begin
                t = done_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(t));
            end
        end
        if (err_op) begin
            if (err_q.size() == 0) begin
                chk("unexpected_err", 64'(err_op), 64'd0);
            end else begin
                t = err_q.pop_front();
                chk("err_cycle", 64'(cyc), 64'(t));
            end
        end
    end

    // Legal transfer of n beats; optionally an intruding request is held
    // for the whole busy window and must be ignored.
    task automatic do_xfer(input logic [3:0] op, input logic [13:0] addr, input logic [2:0] lm,
                           input int n, input logic [3:0] iop, input logic [13:0] iaddr);
        int      t;
        ld_exp_t e;
        @(negedge clk);
        v_lsu_req = 1'b1; v_lsu_op = op; v_data_addr = addr; lmul = lm;
        t = cyc;
        if (op == 4'd1) begin
            for (int b = 0; b < n; b++) begin
                e.cyc = t + 2 + b;
                for (int k = 0; k < 4; k++) e.d[k] = mdl[14'(addr + 14'(4*b + k))];
                ld_q.push_back(e);
            end
        end
        done_q.push_back(t + 1 + n);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            v_lsu_req = (iop != 4'd0); v_lsu_op = iop; v_data_addr = iaddr; lmul = 3'd0;
            chk("busy_in_beat", 64'(v_lsu_busy), 64'd1);
            for (int k = 0; k < 4; k++) begin
                if (op == 4'd2) begin
                    sd[k] = sdata[4*b + k];
                    mdl[14'(addr + 14'(4*b + k))] = sdata[4*b + k];
                end else begin
                    sd[k] = 32'hDEAD_0000 + W'(k);
                end
            end
        end
        @(negedge clk);
        chk("busy_in_done", 64'(v_lsu_busy), 64'd1);
        @(negedge clk);
        v_lsu_req = 1'b0; v_lsu_op = 4'd0;
        chk("busy_after", 64'(v_lsu_busy), 64'd0);
    endtask

    // Request that must be rejected (err_exp=1) or silently ignored.
    task automatic do_err(input logic [3:0] op, input logic [2:0] lm, input bit err_exp);
        @(negedge clk);
        v_lsu_req = 1'b1; v_lsu_op = op; v_data_addr = 14'h0010; lmul = lm;
        for (int k = 0; k < 4; k++) sd[k] = 32'hBAD0_0000 + W'(k);
        if (err_exp) err_q.push_back(cyc + 1);
        @(negedge clk);
        v_lsu_req = 1'b0; v_lsu_op = 4'd0;
        chk("rej_busy_t1", 64'(v_lsu_busy), 64'd0);
        @(negedge clk);
        chk("rej_busy_t2", 64'(v_lsu_busy), 64'd0);
    endtask

    initial begin
        nrst = 1'b1; v_lsu_req = 1'b0; v_lsu_op = 4'd0; v_data_addr = 14'd0; lmul = 3'd0;
        for (int k = 0; k < 4; k++) sd[k] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(v_lsu_busy), 64'd0);
        chk("rst_done", 64'(v_lsu_done), 64'd0);
        chk("rst_valid", 64'(v_load_valid), 64'd0);
        chk("rst_err", 64'(err_op), 64'd0);
`ifdef VDMEM_PERF_EN
        chk("rst_perf_ld", 64'(perf_ld_beats), 64'd0);
        chk("rst_perf_st", 64'(perf_st_beats), 64'd0);
`endif
        nrst = 1'b0;

        // Single beat store/load round trip.
        sdata[0] = 32'h11; sdata[1] = 32'h22; sdata[2] = 32'h33; sdata[3] = 32'h44;
        do_xfer(4'd2, 14'h0010, 3'd0, 1, 4'd0, 14'd0);
        do_xfer(4'd1, 14'h0010, 3'd0, 1, 4'd0, 14'd0);

        // Eight-beat transfer of 0..31.
        for (int i = 0; i < 32; i++) sdata[i] = W'(i);
        do_xfer(4'd2, 14'h0100, 3'd3, 8, 4'd0, 14'd0);
        do_xfer(4'd1, 14'h0100, 3'd3, 8, 4'd0, 14'd0);

        // Misaligned base over a known background.
        for (int i = 0; i < 8; i++) sdata[i] = 32'hC000_0000 + W'(i);
        do_xfer(4'd2, 14'h0000, 3'd1, 2, 4'd0, 14'd0);
        sdata[0] = 32'hAAAA_0001; sdata[1] = 32'hBBBB_0002;
        sdata[2] = 32'hCCCC_0003; sdata[3] = 32'hDDDD_0004;
        do_xfer(4'd2, 14'h0003, 3'd0, 1, 4'd0, 14'd0);
        do_xfer(4'd1, 14'h0003, 3'd0, 1, 4'd0, 14'd0);
        do_xfer(4'd1, 14'h0000, 3'd1, 2, 4'd0, 14'd0);

        // Address wrap at the top of memory.
        for (int i = 0; i < 4; i++) sdata[i] = 32'hD000_0000 + W'(i);
        do_xfer(4'd2, 14'h3FFC, 3'd0, 1, 4'd0, 14'd0);
        for (int i = 0; i < 4; i++) sdata[i] = 32'hE000_0000 + W'(i);
        do_xfer(4'd2, 14'h3FFE, 3'd0, 1, 4'd0, 14'd0);
        do_xfer(4'd1, 14'h3FFE, 3'd0, 1, 4'd0, 14'd0);
        do_xfer(4'd1, 14'h3FFC, 3'd0, 1, 4'd0, 14'd0);
        do_xfer(4'd1, 14'h0000, 3'd0, 1, 4'd0, 14'd0);

        // Rejected and ignored requests leave 0x0010 untouched.
        do_err(4'd7, 3'd0, 1'b1);
        do_err(4'd2, 3'd4, 1'b1);
        do_err(4'd1, 3'd4, 1'b1);
        do_err(4'd0, 3'd0, 1'b0);
        do_xfer(4'd1, 14'h0010, 3'd0, 1, 4'd0, 14'd0);

        // Requests raised while busy are dropped.
        for (int i = 0; i < 8; i++) sdata[i] = 32'hF000_0000 + W'(i);
        do_xfer(4'd2, 14'h0020, 3'd1, 2, 4'd1, 14'h0010);
        do_xfer(4'd1, 14'h0020, 3'd1, 2, 4'd2, 14'h0010);
        do_xfer(4'd1, 14'h0010, 3'd0, 1, 4'd0, 14'd0);

        // Reset during beat 2 of a four-beat store.
        for (int i = 0; i < 16; i++) sdata[i] = 32'h5000_0000 + W'(i);
        do_xfer(4'd2, 14'h0200, 3'd2, 4, 4'd0, 14'd0);
        @(negedge clk);
        v_lsu_req = 1'b1; v_lsu_op = 4'd2; v_data_addr = 14'h0200; lmul = 3'd2;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            v_lsu_req = 1'b0; v_lsu_op = 4'd0;
            for (int k = 0; k < 4; k++) begin
                sd[k] = 32'h6000_0000 + W'(4*b + k);
                if (b < 2) mdl[14'(14'h0200 + 14'(4*b + k))] = sd[k];
            end
            if (b == 2) nrst = 1'b1;
        end
        @(negedge clk);
        chk("abort_busy", 64'(v_lsu_busy), 64'd0);
        chk("abort_done", 64'(v_lsu_done), 64'd0);
        chk("abort_valid", 64'(v_load_valid), 64'd0);
        chk("abort_err", 64'(err_op), 64'd0);
`ifdef VDMEM_PERF_EN
        chk("abort_perf_st", 64'(perf_st_beats), 64'd0);
`endif
        nrst = 1'b0;
        do_xfer(4'd1, 14'h0200, 3'd2, 4, 4'd0, 14'd0);

        repeat (4) @(negedge clk);
        chk("pending_loads", 64'(ld_q.size()), 64'd0);
        chk("pending_done", 64'(done_q.size()), 64'd0);
        chk("pending_err", 64'(err_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
